// File: rtl/pipelined_addsub.sv
// pipelined_addsub: parametrised, pipelined WIDTH-bit add/subtract for the CORDIC X/Y/Z datapath.
//
// The carry chain is cut into STAGES segments of SEG = WIDTH/STAGES bits. Stage k adds operand
// bits [k*SEG +: SEG] using the carry registered by stage k-1. Result chunks that are already
// computed and operand chunks that are still pending travel with the beat.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid, in_ready  operand beat handshake
//   A, B, Cin, sub      operands, carry/borrow-in, mode (0 = add, 1 = subtract)
//   out_valid,out_ready result handshake
//   S, Cout, ovf        sum/difference, carry/borrow-out, signed overflow
//
// Build option: define ADDSUB_SATURATE_EN to clamp S to the most positive or most negative
// value on signed overflow. When it is undefined, S wraps modulo 2^WIDTH.
//
// Flow control is a global stall: every stage advances together when the output register is
// empty or is being drained.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int unsigned SEG = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    // Subtraction is A + ~B + ~Cin; the carry-in inversion happens at stage 0.
    assign b_eff    = sub ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [SEG-1:0]         a_seg;
        logic [SEG-1:0]         b_seg;
        logic                   c_in;
        logic                   sub_in;
        logic                   v_in;
        logic [SEG:0]           seg_sum;
        logic [(k+1)*SEG-1:0]   s_cat;   // all result chunks computed so far, this one on top
        logic [(k+1)*SEG-1:0]   s_res;
        logic                   vld_q;
        logic [(k+1)*SEG-1:0]   s_q;

        if (k == 0) begin : gen_src
            assign a_seg  = A[SEG-1:0];
            assign b_seg  = b_eff[SEG-1:0];
            assign c_in   = Cin ^ sub;
            assign sub_in = sub;
            assign v_in   = in_valid;
            assign s_cat  = seg_sum[SEG-1:0];
        end else begin : gen_src
            assign a_seg  = gen_stage[k-1].gen_mid.a_q[SEG-1:0];
            assign b_seg  = gen_stage[k-1].gen_mid.b_q[SEG-1:0];
            assign c_in   = gen_stage[k-1].gen_mid.c_q;
            assign sub_in = gen_stage[k-1].gen_mid.sub_q;
            assign v_in   = gen_stage[k-1].vld_q;
            assign s_cat  = {seg_sum[SEG-1:0], gen_stage[k-1].s_q};
        end

        assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

        // Data registers load only with a real beat, so a bubble leaves S showing the last
        // result instead of garbage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                s_q   <= '0;
            end else if (adv) begin
                vld_q <= v_in;
                if (v_in) begin
                    s_q <= s_res;
                end
            end
        end

        if (k < STAGES - 1) begin : gen_mid
            localparam int unsigned REM = WIDTH - (k + 1) * SEG;

            logic [REM-1:0] a_up;
            logic [REM-1:0] b_up;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic           c_q;
            logic           sub_q;

            if (k == 0) begin : gen_up
                assign a_up = A[WIDTH-1:SEG];
                assign b_up = b_eff[WIDTH-1:SEG];
            end else begin : gen_up
                assign a_up = gen_stage[k-1].gen_mid.a_q[REM+SEG-1:SEG];
                assign b_up = gen_stage[k-1].gen_mid.b_q[REM+SEG-1:SEG];
            end

            assign s_res = s_cat;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (adv && v_in) begin
                    a_q   <= a_up;
                    b_q   <= b_up;
                    c_q   <= seg_sum[SEG];
                    sub_q <= sub_in;
                end
            end
        end else begin : gen_last
            logic ovf_d;
            logic cout_q;
            logic ovf_q;

            // The top segment carries the operand MSBs, so overflow is decided right here.
            assign ovf_d = (a_seg[SEG-1] == b_seg[SEG-1]) && (seg_sum[SEG-1] != a_seg[SEG-1]);

`ifdef ADDSUB_SATURATE_EN
            always_comb begin
                s_res = s_cat;
                if (ovf_d) begin
                    s_res = a_seg[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign s_res = s_cat;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (adv && v_in) begin
                    // In subtract mode a missing carry means a borrow.
                    cout_q <= seg_sum[SEG] ^ sub_in;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].vld_q;
    assign S         = gen_stage[STAGES-1].s_q;
    assign Cout      = gen_stage[STAGES-1].gen_last.cout_q;
    assign ovf       = gen_stage[STAGES-1].gen_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4).
module tb_pipelined_addsub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;

    pipelined_addsub #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .sub      (sub_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (s),
        .Cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: checks latency, result fields and that out_valid drops afterwards.
    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic ts, input logic [15:0] exp_s,
                           input logic exp_c, input logic exp_o);
        int n;
        a = ta; b = tb; cin = tc; sub_mode = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, STAGES);
        check({tag, "_s"}, s, exp_s);
        check({tag, "_cout"}, cout, exp_c);
        check({tag, "_ovf"}, ovf, exp_o);
        tick();
        check({tag, "_vld_drop"}, out_valid, 0);
    endtask

    initial begin
        int first;
        int last;
        int idx;
        int nb;
        logic acc;
        logic stalled;
        logic [15:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub_mode = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        run_one("add", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);
        run_one("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
        run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
        run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_one("sub_nocin", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        run_one("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
`else
        run_one("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
`endif

        // Back-to-back stream of 8 beats.
        first = -1; last = -1; idx = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                a = 16'(c); b = 16'(3 * c); cin = 1'b0; sub_mode = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("stream_in_ready", in_ready, 1);
            tick();
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                check("stream_s", s, 32'(4 * idx));
                idx++;
            end
        end
        check("stream_first", first, STAGES - 1);
        check("stream_count", idx, 8);
        check("stream_contig", last - first, 7);

        // Same stream with a three-cycle downstream stall.
        nb = 0; idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            out_ready = !(c >= 5 && c < 8);
            if (nb < 8) begin
                a = 16'(nb); b = 16'(3 * nb); cin = 1'b0; sub_mode = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc     = in_valid && in_ready;
            stalled = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                check("bp_s", s, 32'(4 * idx));
                idx++;
            end
            if (stalled) begin
                check("bp_in_ready", in_ready, 0);
                held = s;
            end
            tick();
            if (acc) nb++;
            if (stalled) check("bp_hold", s, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", idx, 8);
        check("bp_drain", out_valid, 0);

        // Reset with three beats in flight.
        for (int c = 0; c < 3; c++) begin
            a = 16'h1111; b = 16'(c); cin = 1'b0; sub_mode = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_s", s, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        for (int c = 0; c < 4; c++) begin
            check("mid_rst_vld", out_valid, 0);
            tick();
        end
        check("mid_rst_vld_end", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
